multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: run  input  1  level; 1 = keep executing instructions, 0 = stop at next instruction boundary.
REQ-004 SHALL have port: opcode  input  3  instruction opcode from instruction register; valid from DECODE onward.
REQ-005 SHALL have port: zero  input  1  ALU zero flag.
REQ-006 SHALL have port: mem_ready  input  1  memory completes current access this cycle.
REQ-007 SHALL have ports, output 1 each: pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a.
REQ-008 SHALL have ports, output 2 each: alu_src_b (00 reg B, 01 const 1, 10 sign-ext imm), alu_op (00 add, 01 sub, 10 funct), pc_source (00 ALU result, 01 ALUOut, 10 jump target).
REQ-009 SHALL have ports: state  output  4  current state; busy  output  1  state != IDLE; illegal  output  1  one-cycle pulse on undefined opcode; retired  output  16  instruction-completion counter.

Function
REQ-010 Opcode map SHALL be: 000 R-type, 100 LW, 101 SW, 110 BEQ, 111 ADDI, 001 J; 010/011 illegal.
REQ-011 States SHALL be encoded: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, R_EXEC 7, R_WB 8, BRANCH 9, JUMP 10, I_EXEC 11, I_WB 12; codes 13-15 SHALL go to IDLE next cycle.
REQ-012 Control outputs SHALL be combinational decode of state (plus zero in BRANCH, mem_ready in memory states); every control not listed for a state SHALL be 0.
REQ-013 IDLE: all controls 0; run=1 -> FETCH, else stay.
REQ-014 FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write =1 only in cycle mem_ready=1; mem_ready=1 -> DECODE, else stay.
REQ-015 DECODE: alu_src_b=10, alu_op=00; next by opcode: LW/SW -> MEM_ADDR, R-type -> R_EXEC, ADDI -> I_EXEC, BEQ -> BRANCH, J -> JUMP, illegal -> illegal=1 this cycle, then FETCH (run=1) or IDLE (run=0).
REQ-016 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; LW -> MEM_RD, SW -> MEM_WR.
REQ-017 MEM_RD: mem_read=1, iord=1; mem_ready=1 -> MEM_WB, else stay.
REQ-018 MEM_WR: mem_write=1, iord=1; wait for mem_ready=1, then end of instruction.
REQ-019 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; end of instruction.
REQ-020 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB; R_WB: reg_write=1, reg_dst=1; end of instruction.
REQ-021 I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> I_WB; I_WB: reg_write=1, reg_dst=0; end of instruction.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write=zero; end of instruction.
REQ-023 JUMP: pc_source=10, pc_write=1; end of instruction.
REQ-024 End of instruction: retired increments by 1 (wraps 0xFFFF -> 0x0000); next state FETCH if run=1, else IDLE; run=0 mid-instruction SHALL NOT abort it.
REQ-025 Illegal opcodes SHALL NOT increment retired.
REQ-026 Zero-wait latencies: R/ADDI/SW 4 cycles, LW 5, BEQ/J 3, illegal 2; each mem_ready=0 cycle adds one.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, retired=0, all outputs 0, independent of clk, including mid-instruction.
REQ-028 After rst_n rises, first transition SHALL occur on the next rising clk edge with run=1.

Verification
REQ-029 Reset mid-LW in MEM_RD -> state=0, mem_read=0, retired=0 same cycle, no clock needed.
REQ-030 run=1, mem_ready=1, opcode 000 -> states 1,2,7,8,1; reg_write=1 only in state 8; retired=1.
REQ-031 opcode 100, mem_ready=0 for 3 cycles in MEM_RD -> states 1,2,3,4,4,4,4,5; total 8 cycles; mem_to_reg=1 in state 5.
REQ-032 opcode 110 with zero=1 then zero=0 -> pc_write=1 then 0 in state 9; both retire.
REQ-033 opcode 011 -> illegal=1 for one cycle in state 2, back to state 1, retired unchanged.
REQ-034 run dropped during R_EXEC -> instruction completes via R_WB, then state=0; retired preset 0xFFFF wraps to 0x0000.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RISC controller: fetch/decode/execute FSM driving datapath
// control lines, plus a retired-instruction counter.
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [2:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic [3:0]  state,
    output logic        busy,
    output logic        illegal,
    output logic [15:0] retired
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        R_EXEC   = 4'd7,
        R_WB     = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        I_EXEC   = 4'd11,
        I_WB     = 4'd12
    } state_t;

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_J    = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    state_t state_q;
    state_t state_d;
    logic   retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= 16'd0;
        end else if (retire) begin
            retired <= retired + 16'd1;
        end
    end

    assign state = state_q;
    assign busy  = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        illegal    = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b10;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_R:         state_d = R_EXEC;
                    OP_ADDI:      state_d = I_EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    default: begin
                        // Undefined opcode is dropped without retiring
                        illegal = 1'b1;
                        state_d = run ? FETCH : IDLE;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = run ? FETCH : IDLE;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = run ? FETCH : IDLE;
                end
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = R_WB;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = run ? FETCH : IDLE;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pc_write  = zero;
                retire    = 1'b1;
                state_d   = run ? FETCH : IDLE;
            end
            JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_d   = run ? FETCH : IDLE;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = I_WB;
            end
            I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = run ? FETCH : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
